// File: rtl/fsqrt_issue_ctrl.sv
// fsqrt_issue_ctrl: request/credit front-end for a fixed-latency fsqrt pipeline.
// Operands issue at most one per cycle; a tag tracker follows each operation
// through the pipeline and its result lands in a first-word-fall-through FIFO.
// Credits count in-flight operations plus FIFO occupancy, so a result always
// has a free slot waiting for it.
module fsqrt_issue_ctrl #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_x,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      sq_x1,
  output logic             sq_enable_in,
  input  logic             sq_enable_out,
  input  logic [31:0]      sq_y,
  input  logic             sq_exception,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic             rsp_exception,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             err_sync,
  output logic             err_overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = TAG_W + 33;
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

  logic             hs, pop, push, do_push, overflow, full;
  logic [CntW-1:0]  used_q, used_d, count_q, count_d;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [EntW-1:0]  mem_q [FIFO_DEPTH];
  logic [TAG_W-1:0] iss_tag_q;
  logic [TAG_W-1:0] tag_q [LATENCY];
  // live: operation still owed a FIFO slot (cleared by flush).
  // issued: operation physically inside fsqrt (survives flush), used for the
  // enable_out cross-check so flushed results emerging later are not errors.
  logic [LATENCY-1:0] live_q, live_d, issued_q, issued_d;
  logic             err_sync_q, err_ovf_q;

  // Handshake, FIFO status and push/pop qualification
  assign req_ready = rstn & ~flush & (used_q < Depth);
  assign hs        = req_valid & req_ready;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign full      = (count_q == Depth);
  assign push      = live_q[LATENCY-1] & ~flush;
  assign do_push   = push & (~full | pop);
  assign overflow  = push & full & ~pop;

  assign {rsp_exception, rsp_y, rsp_tag} = mem_q[rptr_q];
  assign err_sync     = err_sync_q;
  assign err_overflow = err_ovf_q;

  // Issue register driving the fsqrt operand and its valid strobe
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sq_x1        <= '0;
      sq_enable_in <= 1'b0;
      iss_tag_q    <= '0;
    end else begin
      sq_enable_in <= hs;
      if (hs) begin
        sq_x1     <= req_x;
        iss_tag_q <= req_tag;
      end
    end
  end

  // Next state of the tracker valid bits: plain shift fed by the issue strobe
  always_comb begin
    live_d      = '0;
    issued_d    = '0;
    live_d[0]   = sq_enable_in;
    issued_d[0] = sq_enable_in;
    for (int k = 1; k < int'(LATENCY); k++) begin
      live_d[k]   = live_q[k-1];
      issued_d[k] = issued_q[k-1];
    end
  end

  // Tracker valid bits; flush kills ownership but not physical presence
  always_ff @(posedge clk) begin
    if (!rstn) begin
      live_q   <= '0;
      issued_q <= '0;
    end else begin
      live_q   <= flush ? '0 : live_d;
      issued_q <= issued_d;
    end
  end

  // Tracker tags shift alongside the valid bits, never stalling
  always_ff @(posedge clk) begin
    tag_q[0] <= iss_tag_q;
    for (int k = 1; k < int'(LATENCY); k++) begin
      tag_q[k] <= tag_q[k-1];
    end
  end

  // Next-state credit and occupancy counters
  always_comb begin
    used_d = used_q;
    if (hs && !pop) used_d = used_q + CntW'(1);
    else if (!hs && pop) used_d = used_q - CntW'(1);
    if (flush) used_d = '0;

    count_d = count_q;
    if (do_push && !pop) count_d = count_q + CntW'(1);
    else if (!do_push && pop) count_d = count_q - CntW'(1);
    if (flush) count_d = '0;
  end

  // Counters and FIFO pointers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      used_q  <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      used_q  <= used_d;
      count_q <= count_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (do_push) wptr_q <= wptr_q + PtrW'(1);
        if (pop) rptr_q <= rptr_q + PtrW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since rsp_valid qualifies them
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= {sq_exception, sq_y, tag_q[LATENCY-1]};
  end

  // Sticky error flags; only reset clears them
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_sync_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      if (sq_enable_out != issued_q[LATENCY-1]) err_sync_q <= 1'b1;
      if (overflow) err_ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Bench for fsqrt_issue_ctrl: behavioural fsqrt stub plus a transaction-level
// scoreboard (in-order queue of accepted requests with their due cycle).
module tb_fsqrt_issue_ctrl;
  localparam int LAT = 4;
  localparam int DEP = 8;
  localparam int TW  = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic [31:0]   req_x = '0;
  logic [TW-1:0] req_tag = '0;
  logic          rsp_ready = 1'b0;
  logic          force_eo = 1'b0;

  logic          req_ready, sq_enable_in, sq_enable_out, sq_exception;
  logic [31:0]   sq_x1, sq_y, rsp_y;
  logic          rsp_valid, rsp_exception, err_sync, err_overflow;
  logic [TW-1:0] rsp_tag;

  fsqrt_issue_ctrl #(.LATENCY(LAT), .TAG_W(TW), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_tag(req_tag),
    .sq_x1(sq_x1), .sq_enable_in(sq_enable_in), .sq_enable_out(sq_enable_out),
    .sq_y(sq_y), .sq_exception(sq_exception),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_exception(rsp_exception), .rsp_tag(rsp_tag),
    .err_sync(err_sync), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_y(input logic [31:0] x);
    case (x)
      32'h0000_0000: ref_y = 32'h0000_0000;
      32'h3E80_0000: ref_y = 32'h3F00_0000;
      32'h3F80_0000: ref_y = 32'h3F80_0000;
      32'h4080_0000: ref_y = 32'h4000_0000;
      32'h4110_0000: ref_y = 32'h4040_0000;
      32'h4180_0000: ref_y = 32'h4080_0000;
      default:       ref_y = 32'h7FC0_0000;
    endcase
  endfunction

  function automatic logic ref_exc(input logic [31:0] x);
    ref_exc = x[31] && (x[30:0] != '0);
  endfunction

  // Fixed-latency fsqrt stand-in
  logic        pe  [LAT];
  logic [31:0] py  [LAT];
  logic        pex [LAT];
  initial for (int k = 0; k < LAT; k++) begin pe[k] = 1'b0; py[k] = '0; pex[k] = 1'b0; end
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) begin
      pe[k] <= pe[k-1]; py[k] <= py[k-1]; pex[k] <= pex[k-1];
    end
    pe[0]  <= sq_enable_in;
    py[0]  <= ref_y(sq_x1);
    pex[0] <= ref_exc(sq_x1);
  end
  assign sq_enable_out = pe[LAT-1] | force_eo;
  assign sq_y          = py[LAT-1];
  assign sq_exception  = pex[LAT-1];

  typedef struct {
    logic [31:0]   y;
    logic          exc;
    logic [TW-1:0] tag;
    int            rdy;
  } rsp_t;

  rsp_t        q[$];
  int          used_m = 0;
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;
  logic        esync_m = 1'b0;
  logic [31:0] xs [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got %0h exp %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock: check at negedge, advance the model, return 1ns after posedge
  task automatic cycle();
    logic exp_ready, exp_v, hs, pop;
    @(negedge clk);
    exp_ready = rstn && !flush && (used_m < DEP);
    exp_v     = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      chk("rsp_y", rsp_y, q[0].y);
      chk("rsp_exception", 32'(rsp_exception), 32'(q[0].exc));
      chk("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
    end
    chk("err_sync", 32'(err_sync), 32'(esync_m));
    chk("err_overflow", 32'(err_overflow), 32'd0);
    if (!rstn) begin
      q.delete(); used_m = 0; esync_m = 1'b0;
    end else if (flush) begin
      q.delete(); used_m = 0;
    end else begin
      hs  = req_valid && exp_ready;
      pop = exp_v && rsp_ready;
      if (pop) void'(q.pop_front());
      if (hs) q.push_back('{ref_y(req_x), ref_exc(req_x), req_tag, cyc + LAT + 2});
      used_m += int'(hs) - int'(pop);
    end
    if (rstn && force_eo) esync_m = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [31:0] x, input logic [TW-1:0] tag);
    req_valid = 1'b1; req_x = x; req_tag = tag;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    xs[0] = 32'h0000_0000; xs[1] = 32'h3E80_0000; xs[2] = 32'h3F80_0000;
    xs[3] = 32'h4080_0000; xs[4] = 32'h4110_0000; xs[5] = 32'h4180_0000;
    xs[6] = 32'hC080_0000;

    // Reset state
    rstn = 1'b0;
    cycle(); cycle();
    chk("rst sq_enable_in", 32'(sq_enable_in), 32'd0);
    chk("rst sq_x1", sq_x1, 32'd0);
    rstn = 1'b1;
    rsp_ready = 1'b1;
    idle(2);

    // Single op: 4.0 -> 2.0, tag 3, valid exactly LAT+2 cycles later
    issue(32'h4080_0000, 5'd3);
    idle(LAT + 4);

    // Exception and ordering, back to back
    req_valid = 1'b1;
    req_x = 32'h3F80_0000; req_tag = 5'd0; cycle();
    req_x = 32'hC080_0000; req_tag = 5'd1; cycle();
    req_x = 32'h4110_0000; req_tag = 5'd2; cycle();
    idle(LAT + 5);

    // Backpressure: 20 offers with consumer stalled, then drain while offering
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_x = xs[$urandom_range(0, 6)]; req_tag = TW'(i); cycle();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_x = xs[$urandom_range(0, 6)]; req_tag = TW'(i + 20); cycle();
    end

    // Full FIFO: fill it, then pop and issue continuously
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_x = xs[$urandom_range(0, 6)]; req_tag = TW'($urandom); cycle();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req_x = xs[$urandom_range(0, 6)]; req_tag = TW'($urandom); cycle();
    end
    idle(LAT + 12);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_x     = xs[$urandom_range(0, 6)];
      req_tag   = TW'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      cycle();
    end
    flush = 1'b0;
    rsp_ready = 1'b1;
    idle(LAT + 12);

    // Flush mid-flight: three ops, flush two cycles later, then a clean op
    req_valid = 1'b1;
    req_x = 32'h3F80_0000; req_tag = 5'd4; cycle();
    req_x = 32'h4180_0000; req_tag = 5'd5; cycle();
    req_x = 32'h4110_0000; req_tag = 5'd6; cycle();
    idle(1);
    flush = 1'b1; cycle(); flush = 1'b0;
    idle(LAT + 4);
    issue(32'h4080_0000, 5'd7);
    idle(LAT + 4);

    // Spurious enable_out while idle; the flag survives a flush
    force_eo = 1'b1; cycle(); force_eo = 1'b0;
    idle(2);
    flush = 1'b1; cycle(); flush = 1'b0;
    idle(2);

    // One-cycle reset returns everything to its reset value
    rstn = 1'b0; cycle();
    chk("rst2 sq_enable_in", 32'(sq_enable_in), 32'd0);
    chk("rst2 sq_x1", sq_x1, 32'd0);
    rstn = 1'b1;
    idle(3);
    issue(32'h4180_0000, 5'd9);
    idle(LAT + 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
